// File: rtl/q_table_updater_if.sv
// Q-table access bundle: registered read port for the policy path plus the
// valid/ready transition-update channel with its completion outputs.
interface q_table_updater_if #(
  parameter int STATE_W = 4,
  parameter int Q_W     = 16,
  parameter int N_ACT   = 4,
  parameter int ACT_W   = 2
);
  logic [STATE_W-1:0]     rd_state;
  logic [N_ACT*Q_W-1:0]   q_values;
  logic                   upd_valid;
  logic                   upd_ready;
  logic [STATE_W-1:0]     upd_state;
  logic [ACT_W-1:0]       upd_action;
  logic signed [Q_W-1:0]  upd_reward;
  logic [STATE_W-1:0]     upd_next_state;
  logic                   upd_done;
  logic signed [Q_W-1:0]  q_new;

  modport master (
    output rd_state, upd_valid, upd_state, upd_action, upd_reward, upd_next_state,
    input  q_values, upd_ready, upd_done, q_new
  );

  modport slave (
    input  rd_state, upd_valid, upd_state, upd_action, upd_reward, upd_next_state,
    output q_values, upd_ready, upd_done, q_new
  );
endinterface

// File: rtl/q_table_updater.sv
// Q-table owner: registered per-state read port and a 4-cycle read-modify-write
// Q-learning update with shift-based alpha and gamma, saturated to Q_W bits.
module q_table_updater #(
  parameter int STATE_W     = 4,
  parameter int Q_W         = 16,
  parameter int N_ACT       = 4,
  parameter int ACT_W       = 2,
  parameter int ALPHA_SHIFT = 2,
  parameter int GAMMA_SHIFT = 3
) (
  input  logic               clk,
  input  logic               rst,
  q_table_updater_if.slave   bus_if
);
  localparam int N_ENT = 1 << STATE_W;
  localparam int ENT_W = N_ACT * Q_W;
  localparam int WIDE  = Q_W + 2;

  typedef logic [ENT_W-1:0] entry_t;
  typedef enum logic [1:0] {IDLE, READ, CALC, WRITE} state_t;

  function automatic logic signed [Q_W-1:0] lane_max(input entry_t e);
    logic signed [Q_W-1:0] m;
    logic signed [Q_W-1:0] v;
    m = e[Q_W-1:0];
    for (int i = 1; i < N_ACT; i++) begin
      v = e[i*Q_W +: Q_W];
      if (v > m) m = v;
    end
    return m;
  endfunction

  // Two guard bits cover r + gamma*qmax - q_sa over the full Q_W range.
  function automatic logic signed [WIDE-1:0] q_step(input logic signed [Q_W-1:0] q_sa,
                                                    input logic signed [Q_W-1:0] qmax,
                                                    input logic signed [Q_W-1:0] r);
    logic signed [WIDE-1:0] qsa_w, qmax_w, r_w, g, td;
    qsa_w  = q_sa;
    qmax_w = qmax;
    r_w    = r;
    g      = qmax_w - (qmax_w >>> GAMMA_SHIFT);
    td     = r_w + g - qsa_w;
    return qsa_w + (td >>> ALPHA_SHIFT);
  endfunction

  function automatic logic signed [Q_W-1:0] sat_q(input logic signed [WIDE-1:0] x);
    logic [WIDE-Q_W:0] top;
    top = x[WIDE-1:Q_W-1];
    if ((&top) || (~|top)) return x[Q_W-1:0];
    else if (x[WIDE-1])    return {1'b1, {(Q_W-1){1'b0}}};
    else                   return {1'b0, {(Q_W-1){1'b1}}};
  endfunction

  state_t                state_q, state_d;
  logic [STATE_W-1:0]    s_q, sn_q;
  logic [ACT_W-1:0]      a_q;
  logic signed [Q_W-1:0] r_q, qsa_q, qmax_q, qcalc_q, q_new_q;
  entry_t                q_values_q;
  entry_t                table_q [N_ENT];
  logic                  accept;

  assign accept          = (state_q == IDLE) && bus_if.upd_valid;
  assign bus_if.upd_ready = (state_q == IDLE);
  assign bus_if.upd_done  = (state_q == WRITE);
  assign bus_if.q_new     = q_new_q;
  assign bus_if.q_values  = q_values_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus_if.upd_valid) state_d = READ;
      READ:    state_d = CALC;
      CALC:    state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      s_q        <= '0;
      sn_q       <= '0;
      a_q        <= '0;
      r_q        <= '0;
      qsa_q      <= '0;
      qmax_q     <= '0;
      qcalc_q    <= '0;
      q_new_q    <= '0;
      q_values_q <= '0;
      for (int i = 0; i < N_ENT; i++) table_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      // Read port samples the table before this edge's write lands.
      q_values_q <= table_q[bus_if.rd_state];
      if (accept) begin
        s_q  <= bus_if.upd_state;
        a_q  <= bus_if.upd_action;
        r_q  <= bus_if.upd_reward;
        sn_q <= bus_if.upd_next_state;
      end
      if (state_q == READ) begin
        qsa_q  <= table_q[s_q][int'(a_q)*Q_W +: Q_W];
        qmax_q <= lane_max(table_q[sn_q]);
      end
      if (state_q == CALC) qcalc_q <= sat_q(q_step(qsa_q, qmax_q, r_q));
      if (state_q == WRITE) begin
        table_q[s_q][int'(a_q)*Q_W +: Q_W] <= qcalc_q;
        q_new_q                            <= qcalc_q;
      end
    end
  end
endmodule

// File: tb/tb_q_table_updater.sv
// Directed bench for q_table_updater: a reference table model predicts each
// written Q value into a scoreboard queue that is drained as writes complete.
module tb_q_table_updater;
  localparam int STATE_W = 4;
  localparam int Q_W     = 16;
  localparam int N_ACT   = 4;
  localparam int ACT_W   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  q_table_updater_if #(.STATE_W(STATE_W), .Q_W(Q_W), .N_ACT(N_ACT), .ACT_W(ACT_W)) bus();

  q_table_updater #(
    .STATE_W(STATE_W), .Q_W(Q_W), .N_ACT(N_ACT), .ACT_W(ACT_W),
    .ALPHA_SHIFT(2), .GAMMA_SHIFT(3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int mtbl [16][4];
  logic [15:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    check(tag, {48'd0, obs}, {48'd0, exp});
  endtask

  function automatic int model_q(input int qsa, input int qmax, input int r);
    int g, td, t;
    g  = qmax - (qmax >>> 3);
    td = r + g - qsa;
    t  = qsa + (td >>> 2);
    if (t > 32767)  t = 32767;
    if (t < -32768) t = -32768;
    return t;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 4; j++) mtbl[i][j] = 0;
    exp_q.delete();
  endtask

  task automatic drive(input int s, input int a, input int r, input int sn);
    int qmax, qn;
    qmax = mtbl[sn][0];
    for (int j = 1; j < 4; j++) if (mtbl[sn][j] > qmax) qmax = mtbl[sn][j];
    qn = model_q(mtbl[s][a], qmax, r);
    mtbl[s][a] = qn;
    exp_q.push_back(16'(qn));
    bus.upd_state      = 4'(s);
    bus.upd_action     = 2'(a);
    bus.upd_reward     = 16'(r);
    bus.upd_next_state = 4'(sn);
    bus.upd_valid      = 1'b1;
  endtask

  task automatic accept_wait();
    int w = 0;
    while (!bus.upd_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("accept_ready", {63'd0, bus.upd_ready}, 64'd1);
    @(posedge clk);
    #1;
    bus.upd_valid      = 1'b0;
    bus.upd_state      = 4'($urandom);
    bus.upd_action     = 2'($urandom);
    bus.upd_reward     = 16'($urandom);
    bus.upd_next_state = 4'($urandom);
  endtask

  task automatic wait_done();
    int k = 0;
    while (k < 12) begin
      @(negedge clk);
      k++;
      if (k == 1) check("busy_ready", {63'd0, bus.upd_ready}, 64'd0);
      if (bus.upd_done) break;
    end
    check("done_latency", 64'(k), 64'd3);
  endtask

  task automatic check_qnew();
    logic [15:0] e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check16("q_new", bus.q_new, e);
    end
    check("done_pulse", {63'd0, bus.upd_done}, 64'd0);
  endtask

  task automatic send(input int s, input int a, input int r, input int sn);
    drive(s, a, r, sn);
    accept_wait();
    wait_done();
    check_qnew();
  endtask

  initial begin
    int it;
    model_clear();
    bus.rd_state = 4'd5;
    bus.upd_valid = 1'b0;
    bus.upd_state = '0;
    bus.upd_action = '0;
    bus.upd_reward = '0;
    bus.upd_next_state = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_q_values", bus.q_values, 64'd0);
    check("rst_ready", {63'd0, bus.upd_ready}, 64'd1);
    check("rst_done", {63'd0, bus.upd_done}, 64'd0);
    check16("rst_q_new", bus.q_new, 16'd0);

    // Basic update on a zero table, then read the written entry back.
    send(1, 2, 100, 3);
    check16("basic_q_new", bus.q_new, 16'd25);
    bus.rd_state = 4'd1;
    @(negedge clk);
    check("basic_readback", bus.q_values, 64'h0000_0019_0000_0000);

    // Discounted successor max.
    send(3, 0, 256, 4);
    check16("preload_64", bus.q_new, 16'd64);
    send(2, 1, 0, 3);
    check16("gamma_q_new", bus.q_new, 16'd14);

    // Positive saturation.
    it = 0;
    while (mtbl[7][0] != 32767 && it < 40) begin
      send(7, 0, 32767, 7);
      it++;
    end
    send(7, 0, 32767, 7);
    check16("sat_pos", bus.q_new, 16'h7FFF);

    // Negative saturation: every lane of state 8 driven to the minimum.
    for (int a = 0; a < 4; a++) begin
      it = 0;
      while (mtbl[8][a] != -32768 && it < 80) begin
        send(8, a, -32768, 9);
        it++;
      end
    end
    send(8, 0, -32768, 8);
    check16("sat_neg", bus.q_new, 16'h8000);

    // Floor rounding of a negative TD error and read-before-write.
    bus.rd_state = 4'd10;
    drive(10, 0, -1, 11);
    accept_wait();
    wait_done();
    check_qnew();
    check16("neg_round", bus.q_new, 16'hFFFF);
    check("rbw_old", bus.q_values, 64'd0);
    @(negedge clk);
    check("rbw_new", bus.q_values, 64'h0000_0000_0000_FFFF);

    // Request held through WRITE waits for IDLE and sees the first result.
    send(12, 1, 400, 12);
    drive(12, 1, 400, 12);
    accept_wait();
    wait_done();
    drive(12, 1, 400, 12);
    check("write_not_ready", {63'd0, bus.upd_ready}, 64'd0);
    check_qnew();
    check("idle_ready", {63'd0, bus.upd_ready}, 64'd1);
    accept_wait();
    wait_done();
    check_qnew();

    for (int i = 0; i < 12; i++)
      send($urandom_range(0, 15), $urandom_range(0, 3),
           int'($urandom_range(0, 65535)) - 32768, $urandom_range(0, 15));

    // Reset during CALC discards the update and clears the table.
    bus.rd_state = 4'd1;
    drive(5, 3, 1000, 6);
    accept_wait();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ready", {63'd0, bus.upd_ready}, 64'd1);
    check("midrst_done", {63'd0, bus.upd_done}, 64'd0);
    check16("midrst_q_new", bus.q_new, 16'd0);
    check("midrst_q_values", bus.q_values, 64'd0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("postrst_done", {63'd0, bus.upd_done}, 64'd0);
      check("postrst_cleared", bus.q_values, 64'd0);
    end
    send(5, 3, 1000, 6);
    check16("postrst_q_new", bus.q_new, 16'd250);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/q_table_updater.md
Name: q_table_updater

Overview:
- Owns the Q table and is the write side of the Q-value interface; the policy path only reads it.
- The read port supplies registered per-state Q-value vectors, 4 actions × 16-bit packed into 64 bits, to the action-selection logic.
- The update port accepts one (state, action, reward, next_state) transition per handshake.
- Each accepted transition runs a read-modify-write Q-learning update using shift-based alpha and gamma.

Parameters:
STATE_W, 4, state index width; the table holds 2^STATE_W entries.
Q_W, 16, signed width of each Q value and of the reward.
N_ACT, 4, actions per state; an entry is N_ACT*Q_W bits and action a occupies bits [Q_W*a+Q_W-1 : Q_W*a].
ACT_W, 2, action index width (log2 N_ACT).
ALPHA_SHIFT, 2, learning rate alpha = 2^-ALPHA_SHIFT.
GAMMA_SHIFT, 3, discount gamma = 1 - 2^-GAMMA_SHIFT; gamma*x is computed as x - (x>>>GAMMA_SHIFT).

Ports:
clk  in  1  clock; everything is on the rising edge.
rst  in  1  asynchronous, active-high reset.
rd_state  in  STATE_W  state whose Q values are read.
q_values  out  N_ACT*Q_W  registered Q entry of rd_state.
upd_valid  in  1  update request valid.
upd_ready  out  1  high only in IDLE; the request is accepted when upd_valid && upd_ready.
upd_state  in  STATE_W  state s of the transition.
upd_action  in  ACT_W  action a taken in s.
upd_reward  in  Q_W  signed reward r.
upd_next_state  in  STATE_W  successor state s'.
upd_done  out  1  one-cycle pulse in the cycle the table is written.
q_new  out  Q_W  value written; held until the next write.

Behaviour:
- Reset (async, any time, including mid-update):
  - all table entries = 0; q_values = 0; q_new = 0; upd_done = 0.
  - FSM goes to IDLE, upd_ready = 1; any in-flight update is discarded with no write.
- Read port:
  - q_values <= table[rd_state] every cycle, 1-cycle latency.
  - Read-before-write: a write at edge E is visible on q_values only at edge E+1.
- FSM: IDLE -> READ -> CALC -> WRITE -> IDLE.
  - IDLE: upd_ready=1. On upd_valid, latch s, a, r, s' and go to READ.
  - READ: latch q_sa = table[s] lane a, and qmax = signed max of the N_ACT lanes of table[s'].
  - CALC, all signed, widened to Q_W+2 bits, no intermediate overflow:
    - g = qmax - (qmax>>>GAMMA_SHIFT)
    - td = r + g - q_sa
    - q_tmp = q_sa + (td>>>ALPHA_SHIFT), where >>> is arithmetic (floor) shift
    - q_new_c = q_tmp saturated to [-2^(Q_W-1), 2^(Q_W-1)-1]
  - WRITE: table[s] lane a <= q_new_c, other lanes unchanged; q_new <= q_new_c; upd_done=1 for this cycle only.
- Timing: accept edge to write edge is 3 cycles. Maximum throughput is one update per 4 cycles. upd_ready is low in READ, CALC and WRITE.
- Inputs are ignored when upd_ready=0. They may change freely after acceptance; latched copies are used.
- s == s': qmax uses pre-update values.
- Back-to-back updates to the same entry: the second reads the first's written value, because its READ follows that write.
- upd_valid asserted in WRITE is not accepted until the following IDLE cycle.

Test Plan:
- Reset then rd_state=5 -> q_values=0 one cycle later; upd_ready=1, upd_done=0.
- Update s=1, a=2, r=100, s'=3 on a zero table -> upd_done exactly 3 cycles after accept, q_new=25; next cycle rd_state=1 gives q_values=0x0000_0019_0000_0000.
- Preload table[3] lane 0 = 64 (via s=3, a=0 updates), then s=2, a=1, r=0, s'=3 with qmax=64 -> g=56, td=56, update adds 14 to the prior Q of table[2] lane 1 (q_new=14 when that Q is 0).
- Saturation, table preloaded to the Q_W extreme values:
  - q_sa=qmax=32767, r=32767 -> q_tmp=39935 -> q_new=32767.
  - q_sa=qmax=-32768, r=-32768 -> q_tmp=-39936 -> q_new=-32768.
- Negative rounding: q_sa=0, qmax=0, r=-1 -> td>>>2 = -1 -> q_new=-1; rd_state held at s during WRITE shows old value, new value at +1 cycle.
- Assert rst during CALC -> table cleared, no upd_done pulse, upd_ready=1 immediately; a new request 2 cycles after deassertion is processed normally.
